lstm_input_feeder: RTL

//  Upstream feeder for the LSTM core. It collects the quantized 8-bit feature byte stream into packets:
//  64 bytes for branch mode, 8 bytes for system mode. Each packet is packed into the 512-bit iData word.
//  The core reads iData combinationally for its whole run, so a ping-pong pair is used: a fill buffer
//  (being loaded) and a hold buffer (stable, driving oData). The block issues the iNext_valid/iType

---
 rtl/lstm_pkg.sv | 31 +++
 rtl/lstm_input_feeder_if.sv | 28 ++
 rtl/lstm_byte_packer.sv | 58 +++++
 rtl/lstm_input_feeder.sv | 96 +++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// Shared constants, issue-state encoding and packet word helpers for the LSTM input feeder.
// Combinational definitions only; no latency or backpressure.
package lstm_pkg;

  localparam int          PKT_W       = 512;
  localparam int          PKT_BYTES   = PKT_W / 8;
  localparam logic        SYS_TYPE    = 1'b0;
  localparam logic        BR_TYPE     = 1'b1;
  localparam logic [7:0]  ZERO_DATA   = 8'd128;
  localparam int          BR_BYTES    = 64;
  localparam int          SYS_BYTES   = 8;
  localparam int          ACK_TIMEOUT = 4;

  typedef logic [PKT_W-1:0] pkt_word_t;

  typedef enum logic [1:0] {
    H_IDLE,
    H_ACK,
    H_RUN
  } issue_state_t;

  // Unwritten bytes must read as the quantized zero, not 0x00.
  function automatic pkt_word_t pad_word();
    return {PKT_BYTES{ZERO_DATA}};
  endfunction

  function automatic logic [5:0] last_idx(input logic pkt_type);
    return (pkt_type == BR_TYPE) ? 6'(BR_BYTES - 1) : 6'(SYS_BYTES - 1);
  endfunction

endpackage

// File: rtl/lstm_input_feeder_if.sv
// Byte-stream and core-handshake bundle between the feeder and its environment.
// Wiring only; no latency, backpressure carried by oByte_ready.
interface lstm_input_feeder_if;
  import lstm_pkg::*;

  logic       iByte_valid;
  logic [7:0] iByte_data;
  logic       iByte_type;
  logic       iByte_last;
  logic       oByte_ready;
  logic       iLstm_done;
  logic       oNext_valid;
  logic       oType;
  pkt_word_t  oData;
  logic [15:0] oPkt_count;
  logic       oError;

  modport slave (
    input  iByte_valid, iByte_data, iByte_type, iByte_last, iLstm_done,
    output oByte_ready, oNext_valid, oType, oData, oPkt_count, oError
  );

  modport master (
    output iByte_valid, iByte_data, iByte_type, iByte_last, iLstm_done,
    input  oByte_ready, oNext_valid, oType, oData, oPkt_count, oError
  );

endinterface

// File: rtl/lstm_byte_packer.sv
// Packs accepted bytes into a pre-padded 512-bit fill buffer; a packet closes on last or capacity.
// Byte lands in the buffer the cycle after acceptance; byte_rdy_o drops while a closed packet waits for clear_i.
module lstm_byte_packer
  import lstm_pkg::*;
(
  input  logic      clk,
  input  logic      resetn,
  input  logic      byte_vld_i,
  input  logic [7:0] byte_dat_i,
  input  logic      byte_type_i,
  input  logic      byte_last_i,
  output logic      byte_rdy_o,
  input  logic      clear_i,
  output pkt_word_t fill_o,
  output logic      fill_type_o,
  output logic      fill_full_o
);

  pkt_word_t  fill_q;
  logic [5:0] idx_q;
  logic [5:0] idx_d;
  logic       type_q;
  logic       full_q;
  logic       accept;
  logic       pkt_type;
  logic       close;

  // Type is taken from the wire on the first byte so capacity is right for that byte too.
  always_comb begin
    accept   = byte_vld_i && !full_q;
    pkt_type = (idx_q == 6'd0) ? byte_type_i : type_q;
    close    = byte_last_i || (idx_q == last_idx(pkt_type));
    idx_d    = close ? 6'd0 : idx_q + 6'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_q <= pad_word();
      idx_q  <= 6'd0;
      type_q <= SYS_TYPE;
      full_q <= 1'b0;
    end else if (clear_i) begin
      fill_q <= pad_word();
      full_q <= 1'b0;
    end else if (accept) begin
      fill_q[{idx_q, 3'b000} +: 8] <= byte_dat_i;
      type_q <= pkt_type;
      idx_q  <= idx_d;
      full_q <= close;
    end
  end

  assign byte_rdy_o  = !full_q;
  assign fill_o      = fill_q;
  assign fill_type_o = type_q;
  assign fill_full_o = full_q;

endmodule

// File: rtl/lstm_input_feeder.sv
// Ping-pong feeder: fill buffer loads bytes, hold buffer drives oData while the core runs.
// Transfer-to-pulse >= 1 cycle; byte stream stalls only when both fill and hold are occupied.
module lstm_input_feeder
  import lstm_pkg::*;
(
  input logic                 clk,
  input logic                 resetn,
  lstm_input_feeder_if.slave  feed
);

  pkt_word_t    fill_w;
  logic         fill_type;
  logic         fill_full;
  logic         xfer;

  pkt_word_t    hold_q;
  logic         type_q;
  logic         hold_full_q;
  logic         next_vld_q;
  logic [15:0]  cnt_q;
  logic         err_q;
  logic [2:0]   tmo_q;
  issue_state_t st_q;

  // Registered hold_full_q keeps iLstm_done out of any path into the hold contents.
  assign xfer = fill_full && !hold_full_q;

  lstm_byte_packer u_packer (
    .clk         (clk),
    .resetn      (resetn),
    .byte_vld_i  (feed.iByte_valid),
    .byte_dat_i  (feed.iByte_data),
    .byte_type_i (feed.iByte_type),
    .byte_last_i (feed.iByte_last),
    .byte_rdy_o  (feed.oByte_ready),
    .clear_i     (xfer),
    .fill_o      (fill_w),
    .fill_type_o (fill_type),
    .fill_full_o (fill_full)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q      <= pad_word();
      type_q      <= SYS_TYPE;
      hold_full_q <= 1'b0;
      next_vld_q  <= 1'b0;
      cnt_q       <= 16'd0;
      err_q       <= 1'b0;
      tmo_q       <= 3'd0;
      st_q        <= H_IDLE;
    end else begin
      next_vld_q <= 1'b0;
      if (xfer) begin
        hold_q      <= fill_w;
        type_q      <= fill_type;
        hold_full_q <= 1'b1;
      end
      case (st_q)
        H_IDLE: begin
          if (hold_full_q && feed.iLstm_done) begin
            next_vld_q <= 1'b1;
            cnt_q      <= cnt_q + 16'd1;
            tmo_q      <= 3'd0;
            st_q       <= H_ACK;
          end
        end
        H_ACK: begin
          if (!feed.iLstm_done) begin
            st_q <= H_RUN;
          end else if (tmo_q == 3'(ACK_TIMEOUT - 1)) begin
            // Core never acknowledged: flag it and let H_IDLE re-issue the same packet.
            err_q <= 1'b1;
            st_q  <= H_IDLE;
          end else begin
            tmo_q <= tmo_q + 3'd1;
          end
        end
        H_RUN: begin
          if (feed.iLstm_done) begin
            hold_full_q <= 1'b0;
            st_q        <= H_IDLE;
          end
        end
        default: st_q <= H_IDLE;
      endcase
    end
  end

  assign feed.oNext_valid = next_vld_q;
  assign feed.oType       = type_q;
  assign feed.oData       = hold_q;
  assign feed.oPkt_count  = cnt_q;
  assign feed.oError      = err_q;

endmodule
